// File: rtl/temporizador_mag.sv
// Microwave countdown timer: keypad-loaded MM:SS in BCD, decremented once per
// second while the magnetron runs. timer_done decodes 00:00 combinationally.
module temporizador_mag #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic [3:0]    min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0]    min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          key_accept;

    // A digit is only shifted in when it cannot push a value >5 into sec_tens.
    assign key_accept = key_valid && !mag_on && (key_digit <= 4'd9) && (sec_ones_q <= 4'd5);

    assign timer_done = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                        (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

    // Next-state: key shift has priority; otherwise prescale and BCD borrow chain.
    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        presc_d    = presc_q;
        if (key_accept) begin
            min_tens_d = min_ones_q;
            min_ones_d = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = key_digit;
            presc_d    = '0;
        end else if (mag_on && !timer_done) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (sec_ones_q != 4'd0) begin
                    sec_ones_d = sec_ones_q - 4'd1;
                end else begin
                    sec_ones_d = 4'd9;
                    if (sec_tens_q != 4'd0) begin
                        sec_tens_d = sec_tens_q - 4'd1;
                    end else begin
                        sec_tens_d = 4'd5;
                        if (min_ones_q != 4'd0) begin
                            min_ones_d = min_ones_q - 4'd1;
                        end else begin
                            // Not 00:00 here, so min_tens is non-zero.
                            min_ones_d = 4'd9;
                            min_tens_d = min_tens_q - 4'd1;
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State registers; reset and clear both zero the count and the prescaler.
    always_ff @(posedge clk) begin
        if (reset || !clearn) begin
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            presc_q    <= '0;
        end else begin
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            presc_q    <= presc_d;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;

endmodule
